meas_frame_serializer: RTL and testbench

- Consumer side of the measurement-word handshake driven by the TDC measurement controller.
- Accepts 32-bit words ({calib_diff, time1}) presented with w_wr_en, buffers them in an internal FIFO, and returns fifo_writing_done to release the producer.
- Drains the FIFO into a byte-wide serial transmitter as fixed 6-byte frames: sync, 4 data bytes, checksum.

---
 rtl/meas_frame_serializer_if.sv | 32 +++
 rtl/meas_frame_serializer.sv | 144 ++++++++++++++
 tb/tb_meas_frame_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_frame_serializer_if.sv
// Measurement-word handshake and byte-transmitter signals of the frame serializer.
interface meas_frame_serializer_if;
   logic        w_wr_en;
   logic [31:0] data_TO_FIFO;
   logic        fifo_writing_done;
   logic        tx_busy;
   logic        tx_block;
   logic [7:0]  tx_data;
   logic        new_tx_data;

   // Environment side: producer plus serial transmitter.
   modport master (
      output w_wr_en,
      output data_TO_FIFO,
      input  fifo_writing_done,
      output tx_busy,
      output tx_block,
      input  tx_data,
      input  new_tx_data
   );

   // Serializer side.
   modport slave (
      input  w_wr_en,
      input  data_TO_FIFO,
      output fifo_writing_done,
      input  tx_busy,
      input  tx_block,
      output tx_data,
      output new_tx_data
   );
endinterface

// File: rtl/meas_frame_serializer.sv
// Buffers 32-bit measurement words in a FIFO and drains them as 6-byte frames:
// sync byte, four data bytes (MSB first), XOR checksum.
module meas_frame_serializer #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   meas_frame_serializer_if.slave bus,
   output logic [DEPTH_LOG2:0]    fifo_count,
   output logic [7:0]             drop_cnt
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e                state_q, state_d;
   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic [7:0]            drop_q;
   logic                  wr_prev_q, done_q;
   logic [31:0]           frame_q;
   logic [7:0]            chk_q;
   logic [2:0]            byte_idx_q;
   logic [7:0]            tx_data_q;
   logic                  new_tx_q;

   logic                  capture, full, push, pop, send;
   logic [31:0]           head_word;
   logic [7:0]            byte_sel;

   // One capture per request, however long w_wr_en is held.
   assign capture   = bus.w_wr_en & ~wr_prev_q;
   assign full      = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
   assign push      = capture & ~full;
   assign head_word = mem[rd_ptr_q];

   // Write side: edge-detect the request, store or drop, acknowledge next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_prev_q <= 1'b0;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         drop_q    <= '0;
      end else begin
         wr_prev_q <= bus.w_wr_en;
         // Acknowledge even a dropped word so the producer never stalls.
         done_q    <= capture;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (capture && full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   // FIFO storage; contents are only read when count says they are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.data_TO_FIFO;
   end

   // Occupancy and read pointer; simultaneous push and pop cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !pop) count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Read FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (count_q != '0) state_d = StSend;
         StSend:  if (!bus.tx_busy && !bus.tx_block) state_d = StGap;
         StGap:   state_d = (byte_idx_q == 3'd5) ? StIdle : StSend;
         default: state_d = StIdle;
      endcase
   end

   // Read FSM outputs: FIFO pop and byte issue.
   always_comb begin
      pop  = 1'b0;
      send = 1'b0;
      unique case (state_q)
         StIdle:  pop  = (count_q != '0);
         StSend:  send = !bus.tx_busy && !bus.tx_block;
         default: ;
      endcase
   end

   // Byte selection within the frame.
   always_comb begin
      byte_sel = SYNC_BYTE;
      case (byte_idx_q)
         3'd1:    byte_sel = frame_q[31:24];
         3'd2:    byte_sel = frame_q[23:16];
         3'd3:    byte_sel = frame_q[15:8];
         3'd4:    byte_sel = frame_q[7:0];
         3'd5:    byte_sel = chk_q;
         default: byte_sel = SYNC_BYTE;
      endcase
   end

   // Frame register, checksum and byte index; frame_q only loads on a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q    <= '0;
         chk_q      <= '0;
         byte_idx_q <= '0;
      end else if (pop) begin
         frame_q    <= head_word;
         chk_q      <= head_word[31:24] ^ head_word[23:16] ^ head_word[15:8] ^ head_word[7:0];
         byte_idx_q <= '0;
      end else if (state_q == StGap && byte_idx_q != 3'd5) begin
         byte_idx_q <= byte_idx_q + 3'd1;
      end
   end

   // Registered transmitter outputs; tx_data holds between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data_q <= '0;
         new_tx_q  <= 1'b0;
      end else begin
         new_tx_q <= send;
         if (send) tx_data_q <= byte_sel;
      end
   end

   assign bus.fifo_writing_done = done_q;
   assign bus.tx_data           = tx_data_q;
   assign bus.new_tx_data       = new_tx_q;
   assign fifo_count            = count_q;
   assign drop_cnt              = drop_q;
endmodule

// File: tb/tb_meas_frame_serializer.sv
// Directed bench for meas_frame_serializer.
module tb_meas_frame_serializer;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  fifo_count;
   logic [7:0]  drop_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_done   = 0;
   bit          busy_mode = 1'b0;
   logic [7:0]  rx_q [$];
   int          ts_q [$];
   int          base, d0;

   meas_frame_serializer_if bus ();

   meas_frame_serializer #(
      .DEPTH_LOG2 (4),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte and acknowledge collector, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.new_tx_data) begin
         rx_q.push_back(bus.tx_data);
         ts_q.push_back(cyc);
      end
      if (bus.fifo_writing_done) n_done <= n_done + 1;
   end

   // Transmitter model: busy for 20 cycles after each strobe when enabled.
   initial begin
      int busy_ctr;
      busy_ctr    = 0;
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_mode && bus.new_tx_data) busy_ctr = 20;
         else if (busy_ctr > 0) busy_ctr--;
         bus.tx_busy = (busy_ctr != 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [31:0] d, input string tag);
      int seen;
      seen = 0;
      bus.data_TO_FIFO = d;
      bus.w_wr_en      = 1'b1;
      for (int i = 0; i < 8 && seen == 0; i++) begin
         tick();
         seen = int'(bus.fifo_writing_done);
      end
      check({tag, "_ack"}, 32'(seen), 32'd1);
      bus.w_wr_en = 1'b0;
      tick();
   endtask

   task automatic wait_bytes(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && rx_q.size() < target; i++) tick();
      check(tag, 32'(rx_q.size()), 32'(target));
   endtask

   task automatic check_frame(input int b, input logic [31:0] w, input logic [7:0] c,
                              input string tag);
      check({tag, "_sync"}, 32'(rx_q[b]), 32'h0000_00A5);
      check({tag, "_word"}, {rx_q[b+1], rx_q[b+2], rx_q[b+3], rx_q[b+4]}, w);
      check({tag, "_chk"}, 32'(rx_q[b+5]), 32'(c));
   endtask

   function automatic logic [31:0] ovf_word(input int i);
      logic [7:0] k;
      k = 8'(i);
      return {8'h80 | k, 8'hC3, k, 8'h5A};
   endfunction

   function automatic logic [7:0] xor_bytes(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

   initial begin
      bus.w_wr_en      = 1'b0;
      bus.data_TO_FIFO = '0;
      bus.tx_block     = 1'b0;
      rst              = 1'b1;
      repeat (3) tick();
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_new_tx_data", 32'(bus.new_tx_data), 32'd0);
      check("rst_done", 32'(bus.fifo_writing_done), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // Single word with cycle-exact latency.
      d0 = n_done;
      base = rx_q.size();
      bus.data_TO_FIFO = 32'h1234_5678;
      bus.w_wr_en      = 1'b1;
      tick();
      check("t1_done_pulse", 32'(bus.fifo_writing_done), 32'd1);
      check("t1_count_push", 32'(fifo_count), 32'd1);
      bus.w_wr_en = 1'b0;
      tick();
      check("t1_done_one_cycle", 32'(bus.fifo_writing_done), 32'd0);
      check("t1_count_pop", 32'(fifo_count), 32'd0);
      check("t1_no_strobe_yet", 32'(bus.new_tx_data), 32'd0);
      tick();
      check("t1_first_strobe", 32'(bus.new_tx_data), 32'd1);
      check("t1_first_byte", 32'(bus.tx_data), 32'h0000_00A5);
      wait_bytes(base + 6, 40, "t1_bytes");
      repeat (4) tick();
      check_frame(base, 32'h1234_5678, 8'h08, "t1");
      check("t1_strobes", 32'(rx_q.size() - base), 32'd6);
      check("t1_done_count", 32'(n_done - d0), 32'd1);
      check("t1_count_final", 32'(fifo_count), 32'd0);
      check("t1_tx_data_hold", 32'(bus.tx_data), 32'h0000_0008);

      // Backpressure: one byte per busy release, 21 cycles apart.
      busy_mode = 1'b1;
      base = rx_q.size();
      write_word(32'hDEAD_BEEF, "t2_wr");
      wait_bytes(base + 6, 300, "t2_bytes");
      busy_mode = 1'b0;
      repeat (25) tick();
      check_frame(base, 32'hDEAD_BEEF, 8'h22, "t2");
      for (int i = 1; i < 6; i++) check("t2_spacing", 32'(ts_q[base+i] - ts_q[base+i-1]), 32'd21);
      check("t2_strobes", 32'(rx_q.size() - base), 32'd6);

      // Overflow: one word parks in the frame register, 16 fill the FIFO, 2 drop.
      bus.tx_block = 1'b1;
      base = rx_q.size();
      d0 = n_done;
      for (int i = 0; i < 19; i++) write_word(ovf_word(i), "t3_wr");
      tick();
      check("t3_count_full", 32'(fifo_count), 32'd16);
      check("t3_drop", 32'(drop_cnt), 32'd2);
      check("t3_done_count", 32'(n_done - d0), 32'd19);
      check("t3_blocked", 32'(rx_q.size() - base), 32'd0);
      bus.tx_block = 1'b0;
      wait_bytes(base + 17 * 6, 300, "t3_bytes");
      for (int f = 0; f < 17; f++) check_frame(base + 6 * f, ovf_word(f), xor_bytes(ovf_word(f)), "t3");
      check("t3_frame_period", 32'(ts_q[base+12] - ts_q[base+6]), 32'd13);
      repeat (3) tick();
      check("t3_count_empty", 32'(fifo_count), 32'd0);
      check("t3_drop_kept", 32'(drop_cnt), 32'd2);

      // Push and pop in the same cycle.
      bus.tx_block = 1'b1;
      base = rx_q.size();
      write_word(32'hA1B2_C3D4, "t4_wr_a");
      write_word(32'h0F1E_2D3C, "t4_wr_b");
      check("t4_count_one", 32'(fifo_count), 32'd1);
      bus.tx_block = 1'b0;
      tick();
      check("t4_resume", 32'(bus.new_tx_data), 32'd1);
      repeat (11) tick();
      check("t4_count_pre", 32'(fifo_count), 32'd1);
      bus.data_TO_FIFO = 32'h55AA_0F01;
      bus.w_wr_en      = 1'b1;
      tick();
      check("t4_count_pushpop", 32'(fifo_count), 32'd1);
      check("t4_done", 32'(bus.fifo_writing_done), 32'd1);
      bus.w_wr_en = 1'b0;
      tick();
      check("t4_count_hold", 32'(fifo_count), 32'd1);
      wait_bytes(base + 18, 80, "t4_bytes");
      check_frame(base, 32'hA1B2_C3D4, 8'h04, "t4_a");
      check_frame(base + 6, 32'h0F1E_2D3C, 8'h00, "t4_b");
      check_frame(base + 12, 32'h55AA_0F01, 8'hF1, "t4_c");
      repeat (3) tick();

      // Long request yields one capture.
      bus.tx_block = 1'b1;
      base = rx_q.size();
      d0 = n_done;
      write_word(32'h0BAD_F00D, "t5_wr");
      bus.data_TO_FIFO = 32'hCAFE_0001;
      bus.w_wr_en      = 1'b1;
      repeat (50) tick();
      bus.w_wr_en = 1'b0;
      tick();
      check("t5_done_count", 32'(n_done - d0), 32'd2);
      check("t5_count", 32'(fifo_count), 32'd1);
      bus.tx_block = 1'b0;
      wait_bytes(base + 12, 60, "t5_bytes");
      check_frame(base, 32'h0BAD_F00D, 8'h5B, "t5_a");
      check_frame(base + 6, 32'hCAFE_0001, 8'h35, "t5_b");
      repeat (3) tick();

      // Reset mid-frame abandons the frame.
      base = rx_q.size();
      write_word(32'h1357_9BDF, "t6_wr");
      wait_bytes(base + 2, 20, "t6_partial");
      rst = 1'b1;
      tick();
      check("t6_rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("t6_rst_new_tx_data", 32'(bus.new_tx_data), 32'd0);
      check("t6_rst_count", 32'(fifo_count), 32'd0);
      check("t6_rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      repeat (20) tick();
      check("t6_no_more_bytes", 32'(rx_q.size() - base), 32'd2);
      base = rx_q.size();
      write_word(32'h2468_ACE1, "t6_wr2");
      wait_bytes(base + 6, 40, "t6_bytes");
      check_frame(base, 32'h2468_ACE1, 8'h01, "t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
